// File: rtl/alu_trace_buffer.sv
// alu_trace_buffer
// Trace stage that samples the core's PC and ALU result buses, stores (pc, alu)
// pairs in a first-word-fall-through FIFO and stops capturing once HALT_PC has
// been recorded. A consumer drains the FIFO through a valid/ready port.
module alu_trace_buffer #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  HALT_PC  = 8'h03,
    parameter bit          ONLY_CHG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cap_en,
    input  logic [7:0]                 pc_in,
    input  logic [7:0]                 alu_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_pc,
    output logic [7:0]                 out_alu,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    logic [7:0]      last_pc;
    logic [7:0]      last_alu;
    logic            last_vld;

    logic [7:0]      hold_pc;
    logic [7:0]      hold_alu;

    logic            changed;
    logic            cap;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            push_halt;

    // Capture / push / drop / pop decisions for this cycle.
    always_comb begin
        changed   = ~last_vld | (pc_in != last_pc) | (alu_in != last_alu);
        cap       = cap_en & ~done & ((ONLY_CHG == 1'b0) | changed);
        full      = (count_q == CW'(DEPTH));
        pop       = out_valid & out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = cap & (~full | pop);
        drop      = cap & full & ~pop;
        push_halt = push & (pc_in == HALT_PC);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: first push leaves IDLE, a pushed HALT_PC sample halts.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (push_halt) begin
                    state_nxt = HALTED;
                end else if (push) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (push_halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        done = (state == HALTED);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; entries are only ever read
        // while out_valid is set, i.e. after they have been written.
        if (!rst && push) begin
            mem[wr_ptr] <= {pc_in, alu_in};
        end
    end

    // Pointers, occupancy and the last-stored pair used for de-duplication.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            last_pc  <= 8'h00;
            last_alu <= 8'h00;
            last_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                last_pc  <= pc_in;
                last_alu <= alu_in;
                last_vld <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Remember the head shown while valid so the outputs hold once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_pc  <= 8'h00;
            hold_alu <= 8'h00;
        end else if (out_valid) begin
            hold_pc  <= mem[rd_ptr][15:8];
            hold_alu <= mem[rd_ptr][7:0];
        end
    end

    // First-word-fall-through head presentation.
    always_comb begin
        out_valid = (count_q != '0);
        count     = count_q;
        out_pc    = out_valid ? mem[rd_ptr][15:8] : hold_pc;
        out_alu   = out_valid ? mem[rd_ptr][7:0]  : hold_alu;
    end

endmodule

// File: tb/tb_alu_trace_buffer.sv
// tb_alu_trace_buffer
// Directed bench for alu_trace_buffer with default parameters
// (DEPTH=16, HALT_PC=8'h03, ONLY_CHG=1).
module tb_alu_trace_buffer;

    logic       clk;
    logic       rst;
    logic       cap_en;
    logic [7:0] pc_in;
    logic [7:0] alu_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pc;
    logic [7:0] out_alu;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       done;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] model_q[$];

    alu_trace_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .pc_in     (pc_in),
        .alu_in    (alu_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_alu   (out_alu),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cap_en    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        vectors++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (overflow !== 1'b0 || drop_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_ovf: got ovf=%b drop=%h expected 0/00", overflow, drop_cnt);
        end
        vectors++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if (out_pc !== 8'h00 || out_alu !== 8'h00) begin
            errors++; $display("FAIL reset_out: got %h/%h expected 00/00", out_pc, out_alu);
        end
    endtask

    task automatic test_dedup();
        logic [15:0] exp_pairs [3];
        exp_pairs[0] = 16'h0005;
        exp_pairs[1] = 16'h0105;
        exp_pairs[2] = 16'h0107;
        do_reset();
        cap_en = 1'b1;
        pc_in = 8'h00; alu_in = 8'h05;
        tick(); tick(); tick();
        pc_in = 8'h01; alu_in = 8'h05; tick();
        pc_in = 8'h01; alu_in = 8'h07; tick();
        cap_en = 1'b0;
        vectors++;
        if (count !== 5'd3) begin
            errors++; $display("FAIL dedup_count: got %0d expected 3", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({out_pc, out_alu} !== exp_pairs[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL dedup_entry%0d: got v=%b %h/%h expected v=1 %h/%h",
                         i, out_valid, out_pc, out_alu, exp_pairs[i][15:8], exp_pairs[i][7:0]);
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 8'h01 || out_alu !== 8'h07) begin
            errors++;
            $display("FAIL dedup_hold: got v=%b %h/%h expected v=0 01/07", out_valid, out_pc, out_alu);
        end
        // Same pair as the last stored one must not be captured again.
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        vectors++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL dedup_repeat: got %0d expected 0", count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_in  = 8'(i);
            alu_in = 8'hA0 + 8'(i);
            tick();
            if (i == 2) begin
                vectors++;
                if (done !== 1'b0) begin
                    errors++; $display("FAIL halt_early: got done=%b expected 0", done);
                end
            end
            if (i == 3) begin
                vectors++;
                if (done !== 1'b1 || count !== 5'd4) begin
                    errors++; $display("FAIL halt_done: got done=%b count=%0d expected 1/4", done, count);
                end
            end
        end
        cap_en = 1'b0;
        vectors++;
        if (count !== 5'd4 || done !== 1'b1) begin
            errors++; $display("FAIL halt_after: got count=%0d done=%b expected 4/1", count, done);
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        vectors++;
        if (count !== 5'd1 || out_pc !== 8'h03 || out_alu !== 8'hA3) begin
            errors++;
            $display("FAIL halt_last: got count=%0d %h/%h expected 1 03/a3", count, out_pc, out_alu);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        model_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_in  = 8'h10 + 8'(i);
            alu_in = 8'h40 + 8'(i);
            if (i < 16) model_q.push_back({pc_in, alu_in});
            tick();
            if (i == 15) begin
                vectors++;
                if (count !== 5'd16 || overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_full: got count=%0d ovf=%b expected 16/0", count, overflow);
                end
            end
        end
        cap_en = 1'b0;
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd4) begin
            errors++;
            $display("FAIL ovf_state: got count=%0d ovf=%b drop=%0d expected 16/1/4", count, overflow, drop_cnt);
        end
        vectors++;
        if (out_pc !== 8'h10 || out_alu !== 8'h40) begin
            errors++; $display("FAIL ovf_head: got %h/%h expected 10/40", out_pc, out_alu);
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] exp;
        cap_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc_in  = 8'h80 + 8'(i);
            alu_in = 8'hC0 + 8'(i);
            exp = model_q[0];
            vectors++;
            if ({out_pc, out_alu} !== exp) begin
                errors++; $display("FAIL fullpop_head%0d: got %h%h expected %h", i, out_pc, out_alu, exp);
            end
            tick();
            void'(model_q.pop_front());
            model_q.push_back({pc_in, alu_in});
            vectors++;
            if (count !== 5'd16 || drop_cnt !== 8'd4) begin
                errors++;
                $display("FAIL fullpop_cnt%0d: got count=%0d drop=%0d expected 16/4", i, count, drop_cnt);
            end
        end
        cap_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = model_q.pop_front();
            vectors++;
            if ({out_pc, out_alu} !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fullpop_drain%0d: got v=%b %h%h expected v=1 %h", i, out_valid, out_pc, out_alu, exp);
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL fullpop_empty: got count=%0d v=%b expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_in  = 8'h20 + 8'(i);
            alu_in = 8'h60 + 8'(i);
            tick();
        end
        cap_en    = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        vectors++;
        if (count !== 5'd3 || out_pc !== 8'h22) begin
            errors++; $display("FAIL rstmid_pre: got count=%0d pc=%h expected 3/22", count, out_pc);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: got count=%0d v=%b expected 0/0", count, out_valid);
        end
        rst       = 1'b0;
        out_ready = 1'b0;
        cap_en    = 1'b1;
        pc_in     = 8'h20;
        alu_in    = 8'h60;
        tick();
        cap_en = 1'b0;
        vectors++;
        if (count !== 5'd1 || out_valid !== 1'b1 || out_pc !== 8'h20 || out_alu !== 8'h60) begin
            errors++;
            $display("FAIL rstmid_resume: got count=%0d v=%b %h/%h expected 1/1 20/60",
                     count, out_valid, out_pc, out_alu);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cap_en    = 1'b0;
        out_ready = 1'b0;
        pc_in     = 8'h00;
        alu_in    = 8'h00;
        test_reset();
        test_dedup();
        test_halt();
        test_overflow();
        test_full_pop();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
